// File: rtl/tdp_sram_bitmask.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tdp_sram_bitmask                                                 |
// | Brief   : True dual-port SRAM with per-bit write masks, read-first ports,  |
// |           out-of-range detection and a post-reset zero-fill sweep.         |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tdp_sram_bitmask #(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 128,
  parameter int READ_LAT       = 1,
  parameter int CLEAR_ON_RESET = 1,
  localparam int AW            = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              a_req_i,
  input  logic              a_we_i,
  input  logic [AW-1:0]     a_addr_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  input  logic [DATA_W-1:0] a_bmask_i,
  output logic [DATA_W-1:0] a_rdata_o,
  output logic              a_rvalid_o,
  input  logic              b_req_i,
  input  logic              b_we_i,
  input  logic [AW-1:0]     b_addr_i,
  input  logic [DATA_W-1:0] b_wdata_i,
  input  logic [DATA_W-1:0] b_bmask_i,
  output logic [DATA_W-1:0] b_rdata_o,
  output logic              b_rvalid_o,
  output logic              init_done_o,
  output logic              err_oob_o
);

  localparam logic [0:0]    S_CLEAR     = 1'b0;
  localparam logic [0:0]    S_READY     = 1'b1;
  localparam logic [0:0]    c_RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
  localparam int            LAST_IDX    = DEPTH - 1;
  localparam logic [AW:0]   c_DEPTH     = DEPTH[AW:0];
  localparam logic [AW-1:0] c_LAST_ADDR = LAST_IDX[AW-1:0];
  localparam logic [AW-1:0] c_ADDR_ONE  = 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [0:0]        r_state;
  logic [AW-1:0]     r_clr_addr;
  logic              r_init_done;
  logic              r_a_rvalid, r_b_rvalid, r_err;
  logic [DATA_W-1:0] r_a_rdata, r_b_rdata;

  logic              w_a_acc, w_b_acc, w_a_inr, w_b_inr;
  logic              w_a_wr, w_b_wr, w_a_rd, w_b_rd, w_same;
  logic [DATA_W-1:0] w_a_old, w_b_old, w_a_new, w_b_new, w_b_base, w_b_keep;
  logic              w_a_pv, w_b_pv;
  logic [DATA_W-1:0] w_a_pd, w_b_pd;

  assign w_a_acc = a_req_i & r_init_done;
  assign w_b_acc = b_req_i & r_init_done;
  assign w_a_inr = ({1'b0, a_addr_i} < c_DEPTH);
  assign w_b_inr = ({1'b0, b_addr_i} < c_DEPTH);
  assign w_a_wr  = w_a_acc & a_we_i & w_a_inr;
  assign w_b_wr  = w_b_acc & b_we_i & w_b_inr;
  assign w_a_rd  = w_a_acc & ~a_we_i;
  assign w_b_rd  = w_b_acc & ~b_we_i;

  // Out-of-range reads see zero; in-range reads see pre-write contents.
  assign w_a_old = w_a_inr ? r_mem[a_addr_i] : '0;
  assign w_b_old = w_b_inr ? r_mem[b_addr_i] : '0;

  assign w_a_new  = (w_a_old & ~a_bmask_i) | (a_wdata_i & a_bmask_i);
  // On a same-address collision B builds on A's result and yields A's bits.
  assign w_same   = w_a_wr & w_b_wr & (a_addr_i == b_addr_i);
  assign w_b_base = w_same ? w_a_new : w_b_old;
  assign w_b_keep = w_same ? (~b_bmask_i | a_bmask_i) : ~b_bmask_i;
  assign w_b_new  = (w_b_base & w_b_keep) | (b_wdata_i & ~w_b_keep);

  always_ff @(posedge clk_i) begin
    if (r_state == S_CLEAR) begin
      r_mem[r_clr_addr] <= '0;
    end else begin
      if (w_a_wr) r_mem[a_addr_i] <= w_a_new;
      if (w_b_wr) r_mem[b_addr_i] <= w_b_new;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= c_RST_STATE;
      r_clr_addr  <= '0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          if (r_clr_addr == c_LAST_ADDR) begin
            r_state     <= S_READY;
            r_init_done <= 1'b1;
          end else begin
            r_clr_addr <= r_clr_addr + c_ADDR_ONE;
          end
        end
        S_READY: r_init_done <= 1'b1;
      endcase
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    logic              r_a_v1, r_b_v1;
    logic [DATA_W-1:0] r_a_d1, r_b_d1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_a_v1 <= 1'b0;
        r_b_v1 <= 1'b0;
        r_a_d1 <= '0;
        r_b_d1 <= '0;
      end else begin
        r_a_v1 <= w_a_rd;
        r_b_v1 <= w_b_rd;
        if (w_a_rd) r_a_d1 <= w_a_old;
        if (w_b_rd) r_b_d1 <= w_b_old;
      end
    end

    assign w_a_pv = r_a_v1;
    assign w_b_pv = r_b_v1;
    assign w_a_pd = r_a_d1;
    assign w_b_pd = r_b_d1;
  end else begin : g_lat1
    assign w_a_pv = w_a_rd;
    assign w_b_pv = w_b_rd;
    assign w_a_pd = w_a_old;
    assign w_b_pd = w_b_old;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_a_rdata  <= '0;
      r_b_rdata  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_a_rvalid <= w_a_pv;
      r_b_rvalid <= w_b_pv;
      if (w_a_pv) r_a_rdata <= w_a_pd;
      if (w_b_pv) r_b_rdata <= w_b_pd;
      r_err      <= (w_a_acc & ~w_a_inr) | (w_b_acc & ~w_b_inr);
    end
  end

  assign a_rdata_o   = r_a_rdata;
  assign b_rdata_o   = r_b_rdata;
  assign a_rvalid_o  = r_a_rvalid;
  assign b_rvalid_o  = r_b_rvalid;
  assign err_oob_o   = r_err;
  assign init_done_o = r_init_done;

endmodule
`default_nettype wire

// File: doc/tdp_sram_bitmask.md
TDP_SRAM_BITMASK -- requirements
Module: tdp_sram_bitmask

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, word width in bits (1..256).
REQ-002 The block SHALL have parameter DEPTH, default 128, number of words (2..4096; need not be a power of two).
REQ-003 The block SHALL have parameter READ_LAT, default 1, read latency in cycles (legal values 1 or 2).
REQ-004 The block SHALL have parameter CLEAR_ON_RESET, default 1, where 1 means zero-fill the array after reset.
REQ-005 The block SHALL derive the local parameter AW = max(1, $clog2(DEPTH)).
REQ-006 The block SHALL have port clk_i, input, 1 bit, the single clock for both ports, rising edge.
REQ-007 The block SHALL have port rst_ni, input, 1 bit, reset; asynchronous, active-low.
REQ-008 The block SHALL have port a_req_i, input, 1 bit, port A access request.
REQ-009 The block SHALL have port a_we_i, input, 1 bit, port A write when 1, read when 0.
REQ-010 The block SHALL have port a_addr_i, input, AW bits, port A word address.
REQ-011 The block SHALL have port a_wdata_i, input, DATA_W bits, port A write data.
REQ-012 The block SHALL have port a_bmask_i, input, DATA_W bits, port A per-bit write enable.
REQ-013 The block SHALL have port a_rdata_o, output, DATA_W bits, port A read data.
REQ-014 The block SHALL have port a_rvalid_o, output, 1 bit, port A read data valid.
REQ-015 The block SHALL have ports b_req_i, b_we_i, b_addr_i, b_wdata_i, b_bmask_i, b_rdata_o and b_rvalid_o, identical to the port A equivalents but for port B.
REQ-016 The block SHALL have port init_done_o, output, 1 bit, high when the array is ready and requests are accepted.
REQ-017 The block SHALL have port err_oob_o, output, 1 bit, one-cycle pulse on any out-of-range access.

Function
REQ-018 The block SHALL accept a request on a port in a cycle when req is 1 and init_done_o is 1; all other cycles are idle for that port.
REQ-019 An accepted write SHALL update, at the clock edge, only the bits of mem[addr] whose bmask bit is 1.
REQ-020 An accepted read SHALL drive mem[addr] on rdata with rvalid=1 exactly READ_LAT cycles after acceptance; rvalid is 1 for one cycle per read.
REQ-021 rdata SHALL hold its last value while rvalid is 0.
REQ-022 Writes SHALL produce no rvalid pulse.
REQ-023 Every read SHALL be read-first: it returns the array contents from before any write accepted in the same cycle, on either port.
REQ-024 When both ports write the same address in the same cycle, bits whose mask is set on both ports SHALL take port A data, and bits set on one port only SHALL take that port's data.
REQ-025 An accepted access with addr >= DEPTH SHALL not modify the array.
REQ-026 An out-of-range read SHALL return all-zero data with a normal rvalid pulse.
REQ-027 err_oob_o SHALL pulse 1 in the cycle after any out-of-range access on either port.
REQ-028 With READ_LAT=2, the read pipeline SHALL sustain one read per cycle per port with no bubbles.
REQ-029 The init FSM SHALL have states CLEAR and READY.
REQ-030 In CLEAR, the FSM SHALL write zero to one word per cycle, at addresses 0..DEPTH-1 in order, then enter READY; CLEAR lasts DEPTH cycles.
REQ-031 In READY, init_done_o SHALL be 1, and the FSM SHALL stay in READY until reset.
REQ-032 With CLEAR_ON_RESET=0, the FSM SHALL enter READY directly, init_done_o SHALL be 1 the first cycle after reset release, and array contents SHALL be undefined (X) until written.

Reset
REQ-033 On assertion of rst_ni (low), the block SHALL immediately and asynchronously set a_rdata_o and b_rdata_o to 0, set a_rvalid_o, b_rvalid_o, err_oob_o and init_done_o to 0, clear the read pipeline, and set the FSM to CLEAR (or READY when CLEAR_ON_RESET=0).
REQ-034 Assertion of rst_ni SHALL not asynchronously clear the array.
REQ-035 Reset asserted mid-CLEAR SHALL restart the sweep at address 0.
REQ-036 Reset asserted with reads in flight SHALL discard those reads; no rvalid pulse follows.

Verification
REQ-037 Default parameters, release reset, with a_req_i held at 1 for reads: init_done_o rises after exactly 128 cycles, no rvalid pulse occurs before that, and the first read of address 5 returns 0.
REQ-038 A writes 0xFFFF_FFFF to address 3 with mask 0x0000_FFFF, then reads address 3: data 0x0000_FFFF with rvalid exactly 1 cycle later (and 2 cycles later with READ_LAT=2).
REQ-039 In the same cycle, A writes 0xAAAA_AAAA with mask 0xFF00_FF00 and B writes 0x5555_5555 with mask 0xFFFF_0000, both to address 7: a later read of address 7 returns 0xAA55_AA00.
REQ-040 Address 9 holds 0x1234_5678; A writes 0xDEAD_BEEF to address 9 while B reads address 9 in the same cycle: B returns 0x1234_5678, and the next B read returns 0xDEAD_BEEF.
REQ-041 With DEPTH=100, A reads address 120: rdata is 0, rvalid pulses, and err_oob_o pulses once.
REQ-042 With DEPTH=100, B writes to address 120: the array is unchanged (full readback check) and err_oob_o pulses once.
REQ-043 Assert rst_ni low at CLEAR cycle 50 and release it: init_done_o rises a full DEPTH cycles after release.
REQ-044 Assert rst_ni low with a READ_LAT=2 read in flight: rvalid stays 0 and rdata reads 0.
